i2c_bus_arbiter: RTL and testbench
==================================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares the single ADV7513 i2c master (one transfer at a time, START/END/ACK handshake) between
//  NREQ requesters: hdmi_config, HPD/EDID poller, scaler/audio config. Round-robin grant per
//  transaction; replays the master START handshake; returns result + read data to the winner.
//  Watchdog recovers from a hung transfer.
// PARAMETERS
//  NREQ     2          number of requesters, 2..4
//  TIMEOUT  2_000_000  iCLK cycles per transaction before abort (40 ms @ 50 MHz)
// PORTS
//  iCLK          in   1        system clock, 50 MHz
//  iRST_N        in   1        asynchronous, active-low reset
//  req_valid     in   NREQ     request; payload stable while high
//  req_addr      in   NREQ*7   slave address per requester
//  req_wlen      in   NREQ     0: one write byte, 1: two bytes
//  req_wdata1    in   NREQ*8   sub-address
//  req_wdata2    in   NREQ*8   data byte
//  req_read      in   NREQ     1: read transfer
//  rsp_done      out  NREQ     one-cycle pulse, one-hot, transaction finished
//  rsp_nack      out  1        valid with rsp_done: 1 = NACK or timeout
//  rsp_timeout   out  1        valid with rsp_done: 1 = watchdog abort
//  rsp_rdata     out  8        valid with rsp_done when read
//  grant         out  NREQ     one-hot owner, 0 when idle
//  m_addr/m_wlen/m_wdata1/m_wdata2/m_read  out  7/1/8/8/1  to master, latched at grant
//  m_start       out  1        master START level
//  m_end         in   1        master END: low while busy, high when idle
//  m_ack         in   1        master ACK: 1 = slave NACKed
//  m_rdata       in   8        master read byte
// BEHAVIOUR
//  Reset: all outputs 0, state SYNC, rr pointer 0.
//  SYNC: wait m_end==1 (master may be mid-transfer after reset) -> IDLE.
//  IDLE: if any req_valid, pick first set index at/after rr pointer (wrapping); register grant,
//   latch payload to m_*, m_start<=1 -> START. Request visible cycle N -> m_start high N+1.
//  START: hold m_start=1 until m_end==0 -> BUSY.
//  BUSY: m_start<=0; on m_end==1 -> DONE, capture m_ack, m_rdata.
//  DONE: rsp_done[grant]=1 one cycle, nack/rdata valid; rr pointer <= grant+1 mod NREQ;
//   grant<=0 -> IDLE. Earliest regrant: cycle after DONE.
//  Watchdog: 32-bit counter cleared on leaving IDLE, counts in START/BUSY; at TIMEOUT-1:
//   m_start<=0, pulse rsp_done with nack=1, timeout=1, rdata=0, advance pointer -> SYNC.
//  Requester must drop req_valid the cycle after rsp_done; still high = new request.
//  req_valid dropped while granted: ignored, transaction completes, done still pulses.
//  Payload changes after grant: ignored (latched copy drives master).
//  Simultaneous requests: strict rotation; requester i never waits more than NREQ-1
//   transactions. Single requester back-to-back: regranted every transaction.
//  m_end already 0 when entering START (stale): still wait for a full low-then-high cycle.
//  rsp_nack/rsp_timeout/rsp_rdata hold last value between done pulses.
// STRUCTURE
//  Package i2c_arb_pkg: state enum {SYNC,IDLE,START,BUSY,DONE}, I2C_AW=7, I2C_DW=8.
//  Sub-module i2c_rr_pick: combinational round-robin picker (req vector, pointer -> one-hot,
//   valid). Rest in one always_ff block with async reset.
// TESTING
//  Behavioural master model: END low 200 cycles after START, ACK per script.
//  1 req0 write 0x39/0x98/0x03, slave ACKs -> m_start 1 cycle after req, rsp_done[0] once, nack=0.
//  2 req0,req1 both held same cycle, 3 transactions each -> grant order 0,1,0,1,0,1.
//  3 req1 read 0x39/0x42, model returns 0x60 -> rsp_done[1], rsp_rdata=0x60, nack=0.
//  4 model NACKs -> rsp_nack=1, rsp_timeout=0; next grant goes to other requester.
//  5 model never raises END, TIMEOUT=1000 -> done at cycle 1000 of START/BUSY, nack=1,
//   timeout=1, m_start=0; no regrant until m_end==1.
//  6 iRST_N low mid BUSY with m_end=0 -> outputs 0 async; no grant until model raises m_end.

Source files
------------

// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the i2c bus arbiter: FSM states, bus widths, one-hot helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    localparam int I2C_AW = 7;
    localparam int I2C_DW = 8;

    // Index of the set bit of a one-hot vector (up to four requesters).
    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and master-side signal bundle of the i2c bus arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req_valid until rsp_done; master paced by m_end.
interface i2c_bus_arbiter_if #(
    parameter int NREQ = 2
);
    import i2c_arb_pkg::*;

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][I2C_AW-1:0]  req_addr;
    logic [NREQ-1:0]              req_wlen;
    logic [NREQ-1:0][I2C_DW-1:0]  req_wdata1;
    logic [NREQ-1:0][I2C_DW-1:0]  req_wdata2;
    logic [NREQ-1:0]              req_read;

    logic [NREQ-1:0]              rsp_done;
    logic                         rsp_nack;
    logic                         rsp_timeout;
    logic [I2C_DW-1:0]            rsp_rdata;
    logic [NREQ-1:0]              grant;

    logic [I2C_AW-1:0]            m_addr;
    logic                         m_wlen;
    logic [I2C_DW-1:0]            m_wdata1;
    logic [I2C_DW-1:0]            m_wdata2;
    logic                         m_read;
    logic                         m_start;
    logic                         m_end;
    logic                         m_ack;
    logic [I2C_DW-1:0]            m_rdata;

    // Arbiter view.
    modport slave (
        input  req_valid, req_addr, req_wlen, req_wdata1, req_wdata2, req_read,
        input  m_end, m_ack, m_rdata,
        output rsp_done, rsp_nack, rsp_timeout, rsp_rdata, grant,
        output m_addr, m_wlen, m_wdata1, m_wdata2, m_read, m_start
    );

    // Requesters plus i2c master view.
    modport master (
        output req_valid, req_addr, req_wlen, req_wdata1, req_wdata2, req_read,
        output m_end, m_ack, m_rdata,
        input  rsp_done, rsp_nack, rsp_timeout, rsp_rdata, grant,
        input  m_addr, m_wlen, m_wdata1, m_wdata2, m_read, m_start
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; vld low when no request is set.
module i2c_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic            vld
);

    // Scan indices ptr..NREQ-1 first, then 0..ptr-1.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                vld    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!vld && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c master among NREQ requesters, round-robin per transaction, with watchdog.
// Latency: request seen in cycle N raises m_start in N+1; rsp_done one cycle after m_end returns.
// Backpressure: one transaction at a time; others wait with req_valid held until granted.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter int unsigned TIMEOUT = 2_000_000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    i2c_bus_arbiter_if.slave   bus
);

    arb_state_t      state_q, state_d;
    logic [1:0]      rr_ptr;
    logic [31:0]     wd_cnt;
    logic            wd_hit;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_vld;
    logic [1:0]      gnt_idx;
    logic [1:0]      ptr_next;

    i2c_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    assign wd_hit   = ((state_q == START) || (state_q == BUSY)) && (wd_cnt == TIMEOUT - 1);
    assign gnt_idx  = onehot_idx(4'(bus.grant));
    assign ptr_next = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= SYNC;
        else         state_q <= state_d;
    end

    // Next state: SYNC also absorbs a master still busy after reset or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (bus.m_end) state_d = IDLE;
            IDLE:    if (pick_vld) state_d = START;
            START:   if (wd_hit) state_d = SYNC; else if (!bus.m_end) state_d = BUSY;
            BUSY:    if (wd_hit) state_d = SYNC; else if (bus.m_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    // Grant, payload latch, master handshake, watchdog and response registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.grant       <= '0;
            bus.rsp_done    <= '0;
            bus.rsp_nack    <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.m_addr      <= '0;
            bus.m_wlen      <= 1'b0;
            bus.m_wdata1    <= '0;
            bus.m_wdata2    <= '0;
            bus.m_read      <= 1'b0;
            bus.m_start     <= 1'b0;
            rr_ptr          <= 2'd0;
            wd_cnt          <= '0;
        end else begin
            bus.rsp_done <= '0;
            case (state_q)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pick_vld) begin
                        bus.grant   <= pick_gnt;
                        bus.m_start <= 1'b1;
                        for (int i = 0; i < NREQ; i++) begin
                            if (pick_gnt[i]) begin
                                bus.m_addr   <= bus.req_addr[i];
                                bus.m_wlen   <= bus.req_wlen[i];
                                bus.m_wdata1 <= bus.req_wdata1[i];
                                bus.m_wdata2 <= bus.req_wdata2[i];
                                bus.m_read   <= bus.req_read[i];
                            end
                        end
                    end
                end
                START, BUSY: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    if (wd_hit) begin
                        // Abort: report to the owner and move on; SYNC waits for the master.
                        bus.m_start     <= 1'b0;
                        bus.rsp_done    <= bus.grant;
                        bus.rsp_nack    <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        bus.grant       <= '0;
                        rr_ptr          <= ptr_next;
                    end else if (state_q == BUSY) begin
                        bus.m_start <= 1'b0;
                        if (bus.m_end) begin
                            bus.rsp_done    <= bus.grant;
                            bus.rsp_nack    <= bus.m_ack;
                            bus.rsp_timeout <= 1'b0;
                            bus.rsp_rdata   <= bus.m_rdata;
                        end
                    end
                end
                DONE: begin
                    bus.grant <= '0;
                    rr_ptr    <= ptr_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter with a behavioural i2c master model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    localparam int          NREQ = 2;
    localparam int unsigned TOUT = 1000;
    localparam int          XFER = 200;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;

    always #10 iCLK = ~iCLK;

    i2c_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic       model_hang = 1'b0;
    logic       model_nack = 1'b0;
    logic [7:0] model_rd   = 8'h00;
    logic [6:0] seen_addr;
    logic [7:0] seen_w1;

    typedef struct {
        logic [1:0] mask;
        logic [6:0] addr;
        logic [7:0] w1;
        logic [7:0] w2;
        logic       wlen;
        logic       rd;
        logic       nack;
        logic [7:0] mrdata;
        logic [1:0] exp_grant;
        logic       exp_nack;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic mtick();
        @(posedge iCLK);
        #2;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (bus.rsp_done == '0 && cyc < limit) begin
            tick();
            cyc++;
        end
        if (bus.rsp_done == '0) begin
            checks++;
            failures++;
            $display("FAIL done_wait actual=no_pulse required=pulse_within_%0d_cycles", limit);
        end
    endtask

    // Master model: END drops after START, stays low XFER cycles (or while hung), then rises.
    initial begin
        bus.m_end   = 1'b1;
        bus.m_ack   = 1'b0;
        bus.m_rdata = 8'h00;
        seen_addr   = '0;
        seen_w1     = '0;
        forever begin
            mtick();
            if (bus.m_start && bus.m_end) begin
                bus.m_end = 1'b0;
                repeat (XFER) mtick();
                while (model_hang) mtick();
                seen_addr   = bus.m_addr;
                seen_w1     = bus.m_wdata1;
                bus.m_ack   = model_nack;
                bus.m_rdata = model_rd;
                bus.m_end   = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int  cyc;
        bit  flag;
        logic [1:0] e;

        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_wlen   = '0;
        bus.req_wdata1 = '0;
        bus.req_wdata2 = '0;
        bus.req_read   = '0;

        //            mask   addr   w1     w2     wlen  rd    nack  mrdata grant  nack
        tbl[0] = '{2'b01, 7'h39, 8'h98, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0};
        tbl[1] = '{2'b10, 7'h39, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0, 8'h60, 2'b10, 1'b0};
        tbl[2] = '{2'b01, 7'h50, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 8'h00, 2'b01, 1'b1};
        tbl[3] = '{2'b11, 7'h48, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0};
        tbl[4] = '{2'b11, 7'h2A, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0};
        tbl[5] = '{2'b10, 7'h1C, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 2'b10, 1'b0};

        // Reset state.
        #25;
        chk("rst_grant",   32'(bus.grant),       0);
        chk("rst_m_start", 32'(bus.m_start),     0);
        chk("rst_done",    32'(bus.rsp_done),    0);
        chk("rst_nack",    32'(bus.rsp_nack),    0);
        chk("rst_timeout", 32'(bus.rsp_timeout), 0);
        chk("rst_rdata",   32'(bus.rsp_rdata),   0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        tick();
        tick();

        // Table-driven single transactions.
        for (int r = 0; r < 6; r++) begin
            model_nack = tbl[r].nack;
            model_rd   = tbl[r].mrdata;
            for (int i = 0; i < NREQ; i++) begin
                if (tbl[r].exp_grant[i]) begin
                    bus.req_addr[i]   = tbl[r].addr;
                    bus.req_wdata1[i] = tbl[r].w1;
                    bus.req_wdata2[i] = tbl[r].w2;
                    bus.req_wlen[i]   = tbl[r].wlen;
                    bus.req_read[i]   = tbl[r].rd;
                end else begin
                    bus.req_addr[i]   = 7'h11;
                    bus.req_wdata1[i] = 8'h22;
                    bus.req_wdata2[i] = 8'h00;
                    bus.req_wlen[i]   = 1'b0;
                    bus.req_read[i]   = 1'b0;
                end
                bus.req_valid[i] = tbl[r].mask[i];
            end
            tick();
            chk($sformatf("r%0d_start_latency", r), 32'(bus.m_start), 1);
            chk($sformatf("r%0d_grant", r), 32'(bus.grant), 32'(tbl[r].exp_grant));
            for (int i = 0; i < NREQ; i++) begin
                bus.req_addr[i]   = 7'h7F;
                bus.req_wdata1[i] = 8'hFF;
            end
            wait_done(2 * XFER, cyc);
            chk($sformatf("r%0d_done", r),    32'(bus.rsp_done),    32'(tbl[r].exp_grant));
            chk($sformatf("r%0d_nack", r),    32'(bus.rsp_nack),    32'(tbl[r].exp_nack));
            chk($sformatf("r%0d_timeout", r), 32'(bus.rsp_timeout), 0);
            if (tbl[r].rd) chk($sformatf("r%0d_rdata", r), 32'(bus.rsp_rdata), 32'(tbl[r].mrdata));
            chk($sformatf("r%0d_m_addr", r),   32'(seen_addr), 32'(tbl[r].addr));
            chk($sformatf("r%0d_m_wdata1", r), 32'(seen_w1),   32'(tbl[r].w1));
            bus.req_valid = '0;
            tick();
            tick();
        end

        // Both requesters held across six transactions: strict alternation.
        model_nack = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i]   = 7'(8'h20 + i);
            bus.req_wdata1[i] = 8'h01;
            bus.req_read[i]   = 1'b0;
        end
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_done(2 * XFER + 10, cyc);
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr_order_%0d", k), 32'(bus.rsp_done), 32'(e));
            if (k == 5) bus.req_valid = '0;
            tick();
        end
        tick();

        // Hung master: watchdog abort, then no regrant until END returns.
        model_hang    = 1'b1;
        bus.req_valid = 2'b01;
        tick();
        chk("to_m_start_rise", 32'(bus.m_start), 1);
        wait_done(3 * TOUT, cyc);
        chk("to_cycles",  32'(cyc),             32'(TOUT));
        chk("to_done",    32'(bus.rsp_done),    2'b01);
        chk("to_nack",    32'(bus.rsp_nack),    1);
        chk("to_flag",    32'(bus.rsp_timeout), 1);
        chk("to_rdata",   32'(bus.rsp_rdata),   0);
        chk("to_m_start", 32'(bus.m_start),     0);
        bus.req_valid = 2'b10;
        flag = 1'b0;
        repeat (30) begin
            tick();
            if (bus.grant != '0 || bus.m_start) flag = 1'b1;
        end
        chk("to_no_regrant", 32'(flag), 0);
        model_hang = 1'b0;
        cyc = 0;
        while (bus.grant == '0 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("to_regrant", 32'(bus.grant), 2'b10);
        wait_done(2 * XFER + 10, cyc);
        chk("to_next_done",    32'(bus.rsp_done),    2'b10);
        chk("to_next_timeout", 32'(bus.rsp_timeout), 0);
        bus.req_valid = '0;
        tick();
        tick();

        // Asynchronous reset in the middle of a transfer.
        bus.req_addr[0]   = 7'h39;
        bus.req_wdata1[0] = 8'h98;
        bus.req_valid     = 2'b01;
        tick();
        repeat (50) tick();
        chk("ar_pre_m_addr", 32'(bus.m_addr), 32'h39);
        #3 iRST_N = 1'b0;
        #1;
        chk("ar_grant",   32'(bus.grant),   0);
        chk("ar_m_start", 32'(bus.m_start), 0);
        chk("ar_m_addr",  32'(bus.m_addr),  0);
        #2 iRST_N = 1'b1;
        flag = 1'b0;
        cyc  = 0;
        while (!bus.m_end && cyc < 2 * XFER) begin
            tick();
            if (!bus.m_end && bus.grant != '0) flag = 1'b1;
            cyc++;
        end
        chk("ar_no_grant_busy", 32'(flag), 0);
        chk("ar_m_end_back", 32'(bus.m_end), 1);
        cyc = 0;
        while (bus.grant == '0 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("ar_regrant", 32'(bus.grant), 2'b01);
        wait_done(2 * XFER + 10, cyc);
        chk("ar_done", 32'(bus.rsp_done), 2'b01);
        bus.req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
